// File: rtl/tt_print_seq_if.sv
// Bus bundle for the console print sequencer.
// Carries the adapter write port, FIFO status, the translator lookup port and
// the printer magnet/status outputs.
//   master : adapter / translator / printer side (drives i_*, observes o_*)
//   slave  : the sequencer itself (observes i_*, drives o_*)
interface tt_print_seq_if #(
  parameter int unsigned DEPTH = 8
) ();
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  // Adapter write side and FIFO status
  logic             i_wr;
  logic [7:0]       i_wr_data;
  logic             o_full;
  logic             o_empty;
  logic [CNT_W-1:0] o_count;
  logic             o_overflow;

  // Translator lookup port
  logic [7:0]       o_xlat_data;
  logic [5:0]       i_xlat_tt;
  logic             i_xlat_lc;
  logic             i_xlat_uc;

  // Printer magnets and status
  logic [5:0]       o_tt;
  logic             o_print_strobe;
  logic             o_shift_up;
  logic             o_shift_down;
  logic             o_space;
  logic             o_cr;
  logic             o_reject;
  logic             o_case_upper;
  logic             o_busy;

  modport master (
    output i_wr, i_wr_data, i_xlat_tt, i_xlat_lc, i_xlat_uc,
    input  o_full, o_empty, o_count, o_overflow, o_xlat_data, o_tt,
           o_print_strobe, o_shift_up, o_shift_down, o_space, o_cr,
           o_reject, o_case_upper, o_busy
  );

  modport slave (
    input  i_wr, i_wr_data, i_xlat_tt, i_xlat_lc, i_xlat_uc,
    output o_full, o_empty, o_count, o_overflow, o_xlat_data, o_tt,
           o_print_strobe, o_shift_up, o_shift_down, o_space, o_cr,
           o_reject, o_case_upper, o_busy
  );
endinterface

// File: rtl/tt_print_seq.sv
// Buffered print sequencer for the console typewriter.
// EBCDIC bytes are queued in a circular FIFO and fed one at a time to the
// printer: each byte becomes a print cycle (with case shift if needed), a
// space, a carriage return, or is rejected as unprintable.
// Ports:
//   i_clk   : clock
//   i_reset : asynchronous active-high reset
//   bus     : tt_print_seq_if.slave (write port, FIFO status, translator
//             lookup, printer magnets, case/busy status)
module tt_print_seq #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned PRINT_CYC  = 16,
  parameter int unsigned SHIFT_CYC  = 24,
  parameter int unsigned CR_CYC     = 64,
  parameter logic [7:0]  SPACE_CODE = 8'h40,
  parameter logic [7:0]  NL_CODE    = 8'h15
) (
  input logic           i_clk,
  input logic           i_reset,
  tt_print_seq_if.slave bus
);
  localparam int unsigned AW      = $clog2(DEPTH);
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
  localparam int unsigned MAX_PS  = (PRINT_CYC > SHIFT_CYC) ? PRINT_CYC : SHIFT_CYC;
  localparam int unsigned MAX_CYC = (MAX_PS > CR_CYC) ? MAX_PS : CR_CYC;
  localparam int unsigned DUR_W   = $clog2(MAX_CYC) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECIDE, S_SHIFT, S_PRINT, S_SPACE, S_CR
  } state_e;

  state_e           state_q;
  logic [7:0]       mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q;
  logic             full_c, empty_c, wr_ok_c, pop_c;

  logic [7:0]       hold_q;
  logic [DUR_W-1:0] dur_q;
  logic [5:0]       tt_q;
  logic             strobe_q, shift_up_q, shift_down_q, space_q, cr_q;
  logic             case_upper_q;

  logic             is_space_c, is_nl_c, unprintable_c, want_upper_c, need_shift_c;

  // FIFO status; full is taken from the registered count so a same-cycle pop
  // never lets a write into a full FIFO.
  assign full_c  = (count_q == CNT_W'(DEPTH));
  assign empty_c = (count_q == '0);
  assign wr_ok_c = bus.i_wr & ~full_c;
  assign pop_c   = (state_q == S_FETCH);

  // FIFO pointer/occupancy next state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_ok_c) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_c)   rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CNT_W'(wr_ok_c) - CNT_W'(pop_c);
  end

  // FIFO storage; contents need no reset since the pointers define validity
  always_ff @(posedge i_clk) begin
    if (wr_ok_c) mem_q[wr_ptr_q] <= bus.i_wr_data;
  end

  // FIFO control registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= bus.i_wr & full_c;
    end
  end

  // Character classification of the held byte (translator answers for hold_q)
  always_comb begin
    is_space_c    = (hold_q == SPACE_CODE);
    is_nl_c       = (hold_q == NL_CODE);
    unprintable_c = ~bus.i_xlat_lc & ~bus.i_xlat_uc;
    want_upper_c  = bus.i_xlat_uc & ~bus.i_xlat_lc;
    // Characters on both hemispheres print in either case
    need_shift_c  = (bus.i_xlat_uc ^ bus.i_xlat_lc) & (want_upper_c != case_upper_q);
  end

  // Sequencer FSM with registered magnet outputs
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= S_IDLE;
      hold_q       <= '0;
      dur_q        <= '0;
      tt_q         <= '0;
      strobe_q     <= 1'b0;
      shift_up_q   <= 1'b0;
      shift_down_q <= 1'b0;
      space_q      <= 1'b0;
      cr_q         <= 1'b0;
      case_upper_q <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!empty_c) state_q <= S_FETCH;
        end
        S_FETCH: begin
          hold_q  <= mem_q[rd_ptr_q];
          state_q <= S_DECIDE;
        end
        S_DECIDE: begin
          if (is_space_c) begin
            state_q <= S_SPACE;
            space_q <= 1'b1;
            dur_q   <= DUR_W'(PRINT_CYC - 1);
          end else if (is_nl_c) begin
            state_q <= S_CR;
            cr_q    <= 1'b1;
            dur_q   <= DUR_W'(CR_CYC - 1);
          end else if (unprintable_c) begin
            state_q <= S_IDLE;
          end else if (need_shift_c) begin
            state_q      <= S_SHIFT;
            shift_up_q   <= want_upper_c;
            shift_down_q <= ~want_upper_c;
            dur_q        <= DUR_W'(SHIFT_CYC - 1);
          end else begin
            state_q  <= S_PRINT;
            tt_q     <= bus.i_xlat_tt;
            strobe_q <= 1'b1;
            dur_q    <= DUR_W'(PRINT_CYC - 1);
          end
        end
        S_SHIFT: begin
          if (dur_q == '0) begin
            shift_up_q   <= 1'b0;
            shift_down_q <= 1'b0;
            case_upper_q <= ~case_upper_q;
            state_q      <= S_PRINT;
            tt_q         <= bus.i_xlat_tt;
            strobe_q     <= 1'b1;
            dur_q        <= DUR_W'(PRINT_CYC - 1);
          end else begin
            dur_q <= dur_q - DUR_W'(1);
          end
        end
        S_PRINT: begin
          if (dur_q == '0) begin
            tt_q    <= '0;
            state_q <= S_IDLE;
          end else begin
            dur_q <= dur_q - DUR_W'(1);
          end
        end
        S_SPACE: begin
          if (dur_q == '0) begin
            space_q <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            dur_q <= dur_q - DUR_W'(1);
          end
        end
        S_CR: begin
          if (dur_q == '0) begin
            cr_q    <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            dur_q <= dur_q - DUR_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Output mapping
  assign bus.o_full         = full_c;
  assign bus.o_empty        = empty_c;
  assign bus.o_count        = count_q;
  assign bus.o_overflow     = overflow_q;
  assign bus.o_xlat_data    = hold_q;
  assign bus.o_tt           = tt_q;
  assign bus.o_print_strobe = strobe_q;
  assign bus.o_shift_up     = shift_up_q;
  assign bus.o_shift_down   = shift_down_q;
  assign bus.o_space        = space_q;
  assign bus.o_cr           = cr_q;
  // Reject is decided from the translator answer during the DECIDE cycle itself
  assign bus.o_reject       = (state_q == S_DECIDE) & ~is_space_c & ~is_nl_c & unprintable_c;
  assign bus.o_case_upper   = case_upper_q;
  assign bus.o_busy         = (state_q != S_IDLE) | ~empty_c;
endmodule

// File: tb/tb_tt_print_seq.sv
// Bench for tt_print_seq: translator model, printer-event monitor and a
// timeline reference model of the byte stream.
module tb_tt_print_seq;
  localparam int unsigned DEPTH = 8;
  localparam int PRINT_CYC = 16;
  localparam int SHIFT_CYC = 24;
  localparam int CR_CYC    = 64;
  localparam int K_UP = 0, K_DN = 1, K_PRINT = 2, K_SPACE = 3, K_CR = 4, K_REJ = 5;

  typedef struct { int kind; int start; int len; int val; } op_t;
  typedef struct { int at; int upper; } strobe_t;
  typedef logic [7:0] byte_q_t [$];

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   m_case = 0;
  int   ovf_seen = 0;
  bit   full_seen = 1'b0;
  op_t     obs_ops[$], exp_ops[$];
  strobe_t obs_str[$], exp_str[$];

  tt_print_seq_if #(.DEPTH(DEPTH)) bus ();

  tt_print_seq #(
    .DEPTH(DEPTH), .PRINT_CYC(PRINT_CYC), .SHIFT_CYC(SHIFT_CYC), .CR_CYC(CR_CYC),
    .SPACE_CODE(8'h40), .NL_CODE(8'h15)
  ) dut (
    .i_clk(clk),
    .i_reset(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Translator model: returns {uc, lc}
  function automatic logic [1:0] xl_class(input logic [7:0] b);
    if (b[3:0] == 4'hF) return 2'b00;
    if (b[3:0] == 4'hE) return 2'b11;
    return b[6] ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [5:0] xl_tt(input logic [7:0] b);
    return (b[5:0] == 6'd0) ? 6'h3F : b[5:0];
  endfunction

  always_comb begin
    bus.i_xlat_tt = xl_tt(bus.o_xlat_data);
    {bus.i_xlat_uc, bus.i_xlat_lc} = xl_class(bus.o_xlat_data);
  end

  function automatic op_t mk_op(input int k, input int s, input int l, input int v);
    op_t o;
    o.kind = k; o.start = s; o.len = l; o.val = v;
    return o;
  endfunction

  function automatic strobe_t mk_str(input int a, input int u);
    strobe_t s;
    s.at = a; s.upper = u;
    return s;
  endfunction

  // Monitor: collapse held outputs into (kind, start cycle, length, o_tt at start)
  bit prev [5];
  int st [5];
  int ln [5];
  int vv [5];
  always @(negedge clk) begin
    logic sig [5];
    sig[0] = bus.o_shift_up;
    sig[1] = bus.o_shift_down;
    sig[2] = (bus.o_tt != 6'd0);
    sig[3] = bus.o_space;
    sig[4] = bus.o_cr;
    if (rst) begin
      for (int k = 0; k < 5; k++) prev[k] = 1'b0;
    end else begin
      for (int k = 0; k < 5; k++) begin
        if (sig[k]) begin
          if (!prev[k]) begin
            st[k] = cyc; ln[k] = 0; vv[k] = int'(bus.o_tt);
          end
          ln[k]++;
        end else if (prev[k]) begin
          obs_ops.push_back(mk_op(k, st[k], ln[k], vv[k]));
        end
        prev[k] = sig[k];
      end
      if (bus.o_reject) obs_ops.push_back(mk_op(K_REJ, cyc, 1, 0));
      if (bus.o_print_strobe) obs_str.push_back(mk_str(cyc, int'(bus.o_case_upper)));
      if (bus.o_overflow) ovf_seen++;
      if (bus.o_full) full_seen = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference timeline: first byte reaches DECIDE at t_dec; each later byte
  // reaches DECIDE three cycles after the previous operation's last cycle.
  task automatic model_run(input byte_q_t bytes, input int t_dec, output int idle_cyc);
    int t;
    t = t_dec;
    idle_cyc = t_dec;
    foreach (bytes[i]) begin
      logic [7:0] b;
      logic [1:0] cls;
      int start;
      b = bytes[i];
      cls = xl_class(b);
      if (b == 8'h40) begin
        exp_ops.push_back(mk_op(K_SPACE, t + 1, PRINT_CYC, 0));
        idle_cyc = t + 1 + PRINT_CYC;
        t = t + PRINT_CYC + 3;
      end else if (b == 8'h15) begin
        exp_ops.push_back(mk_op(K_CR, t + 1, CR_CYC, 0));
        idle_cyc = t + 1 + CR_CYC;
        t = t + CR_CYC + 3;
      end else if (cls == 2'b00) begin
        exp_ops.push_back(mk_op(K_REJ, t, 1, 0));
        idle_cyc = t + 1;
        t = t + 3;
      end else begin
        start = t + 1;
        if (cls != 2'b11 && int'(cls[1]) != m_case) begin
          exp_ops.push_back(mk_op(cls[1] ? K_UP : K_DN, start, SHIFT_CYC, 0));
          m_case = int'(cls[1]);
          start = start + SHIFT_CYC;
        end
        exp_ops.push_back(mk_op(K_PRINT, start, PRINT_CYC, int'(xl_tt(b))));
        exp_str.push_back(mk_str(start, m_case));
        idle_cyc = start + PRINT_CYC;
        t = start + PRINT_CYC + 2;
      end
    end
  endtask

  task automatic compare_run(input string tag);
    int n;
    check($sformatf("%s:op_count", tag), obs_ops.size(), exp_ops.size());
    n = (obs_ops.size() < exp_ops.size()) ? obs_ops.size() : exp_ops.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s:op%0d_kind", tag, i), obs_ops[i].kind, exp_ops[i].kind);
      check($sformatf("%s:op%0d_start", tag, i), obs_ops[i].start, exp_ops[i].start);
      check($sformatf("%s:op%0d_len", tag, i), obs_ops[i].len, exp_ops[i].len);
      check($sformatf("%s:op%0d_tt", tag, i), obs_ops[i].val, exp_ops[i].val);
    end
    check($sformatf("%s:strobe_count", tag), obs_str.size(), exp_str.size());
    n = (obs_str.size() < exp_str.size()) ? obs_str.size() : exp_str.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s:strobe%0d_cycle", tag, i), obs_str[i].at, exp_str[i].at);
      check($sformatf("%s:strobe%0d_case", tag, i), obs_str[i].upper, exp_str[i].upper);
    end
  endtask

  // Write wbytes back-to-back from idle; mbytes are the bytes expected to be accepted
  task automatic run_bytes(input string tag, input byte_q_t wbytes, input byte_q_t mbytes);
    int w, idle_exp, n;
    obs_ops.delete(); obs_str.delete(); exp_ops.delete(); exp_str.delete();
    ovf_seen = 0;
    full_seen = 1'b0;
    w = cyc;
    foreach (wbytes[i]) begin
      bus.i_wr = 1'b1;
      bus.i_wr_data = wbytes[i];
      step();
    end
    bus.i_wr = 1'b0;
    if (wbytes.size() == 1) begin
      check({tag, ":count_c1"}, 32'(bus.o_count), 1);
      step();
      check({tag, ":count_fetch"}, 32'(bus.o_count), 1);
      check({tag, ":busy_fetch"}, 32'(bus.o_busy), 1);
      step();
      check({tag, ":count_decide"}, 32'(bus.o_count), 0);
    end
    model_run(mbytes, w + 3, idle_exp);
    n = 0;
    while (bus.o_busy && n < 3000) begin
      step();
      n++;
    end
    check({tag, ":busy_timeout"}, 32'(bus.o_busy), 0);
    check({tag, ":busy_fall_cycle"}, cyc, idle_exp);
    step();
    compare_run(tag);
    check({tag, ":case_upper"}, 32'(bus.o_case_upper), m_case);
    check({tag, ":empty_end"}, 32'(bus.o_empty), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    byte_q_t wb, mb;
    logic [7:0] rb;
    int w;

    // Reset with a write held high
    rst = 1'b1;
    bus.i_wr = 1'b1;
    bus.i_wr_data = 8'h81;
    repeat (3) step();
    check("rst:empty", 32'(bus.o_empty), 1);
    check("rst:full", 32'(bus.o_full), 0);
    check("rst:count", 32'(bus.o_count), 0);
    check("rst:overflow", 32'(bus.o_overflow), 0);
    check("rst:xlat_data", 32'(bus.o_xlat_data), 0);
    check("rst:tt", 32'(bus.o_tt), 0);
    check("rst:strobe", 32'(bus.o_print_strobe), 0);
    check("rst:shift", 32'({bus.o_shift_up, bus.o_shift_down}), 0);
    check("rst:space_cr", 32'({bus.o_space, bus.o_cr}), 0);
    check("rst:reject", 32'(bus.o_reject), 0);
    check("rst:case", 32'(bus.o_case_upper), 0);
    check("rst:busy", 32'(bus.o_busy), 0);
    rst = 1'b0;
    bus.i_wr = 1'b0;
    step();
    check("rst:no_write_after", 32'(bus.o_count), 0);
    m_case = 0;

    // Single lower-case print
    wb.delete(); wb.push_back(8'h81);
    run_bytes("single", wb, wb);

    // Upper then lower: two shifts
    wb.delete(); wb.push_back(8'hC1); wb.push_back(8'h81);
    run_bytes("shift", wb, wb);

    // Ten-byte burst: one dropped at the tail
    wb.delete(); mb.delete();
    for (int i = 0; i < 10; i++) begin
      rb = 8'($urandom);
      wb.push_back(rb);
      if (i < 9) mb.push_back(rb);
    end
    run_bytes("burst", wb, mb);
    check("burst:overflow_pulses", ovf_seen, 1);
    check("burst:full_seen", 32'(full_seen), 1);

    // Space, new line, unprintable
    wb.delete(); wb.push_back(8'h40); wb.push_back(8'h15); wb.push_back(8'hFF);
    run_bytes("sp_nl_rej", wb, wb);

    // Random bursts that fit in the FIFO
    for (int r = 0; r < 3; r++) begin
      int len;
      len = int'($urandom_range(1, DEPTH));
      wb.delete();
      for (int i = 0; i < len; i++) wb.push_back(8'($urandom));
      run_bytes($sformatf("rand%0d", r), wb, wb);
    end

    // Reset in the 10th shift cycle with 3 bytes still queued
    wb.delete();
    wb.push_back((m_case != 0) ? 8'h81 : 8'hC1);
    wb.push_back(8'h81); wb.push_back(8'hC1); wb.push_back(8'h40);
    w = cyc;
    foreach (wb[i]) begin
      bus.i_wr = 1'b1;
      bus.i_wr_data = wb[i];
      step();
    end
    bus.i_wr = 1'b0;
    while (cyc < w + 13) step();
    check("mid:shift_active", 32'(bus.o_shift_up | bus.o_shift_down), 1);
    check("mid:count", 32'(bus.o_count), 3);
    rst = 1'b1;
    #1;
    check("mid:shift_dropped", 32'({bus.o_shift_up, bus.o_shift_down}), 0);
    check("mid:count_zero", 32'(bus.o_count), 0);
    check("mid:empty", 32'(bus.o_empty), 1);
    check("mid:case", 32'(bus.o_case_upper), 0);
    check("mid:busy", 32'(bus.o_busy), 0);
    check("mid:tt", 32'(bus.o_tt), 0);
    repeat (3) step();
    rst = 1'b0;
    m_case = 0;
    obs_ops.delete(); obs_str.delete();
    repeat (100) step();
    check("mid:no_ops_after", obs_ops.size(), 0);
    check("mid:no_strobe_after", obs_str.size(), 0);
    check("mid:idle_after", 32'(bus.o_busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tt_print_seq.md
# tt_print_seq

Buffered print sequencer for the 1052/2150 console typewriter path. It accepts EBCDIC bytes from the adapter data path into a parametrised FIFO and drives the printer one character at a time. For each byte it issues a tilt/rotate print cycle, a space, or a carriage return, and inserts upper/lower case shift cycles whenever the character's case differs from the tracked shift state. Byte-to-tilt/rotate lookup is done by the team's combinational 8-bit translator, attached through a lookup port.

## Interface
- DEPTH, 8: FIFO entries; power of 2, ≥2
- PRINT_CYC, 16: cycles per print or space operation; ≥1
- SHIFT_CYC, 24: cycles per case shift; ≥1
- CR_CYC, 64: cycles per carriage return; ≥1
- SPACE_CODE, 8'h40: EBCDIC space
- NL_CODE, 8'h15: EBCDIC new line

Ports:
- i_clk  in  1  clock
- i_reset  in  1  asynchronous, active-high reset
- i_wr  in  1  write strobe for i_wr_data
- i_wr_data  in  8  EBCDIC byte
- o_full  out  1  FIFO holds DEPTH entries
- o_empty  out  1  FIFO holds 0 entries
- o_count  out  $clog2(DEPTH+1)  FIFO occupancy
- o_overflow  out  1  one-cycle pulse: write dropped
- o_xlat_data  out  8  byte presented to translator
- i_xlat_tt  in  6  translator tilt/rotate code {t1,t2,r1,r2,r2a,r5}
- i_xlat_lc  in  1  translator: character on lower hemisphere
- i_xlat_uc  in  1  translator: character on upper hemisphere
- o_tt  out  6  tilt/rotate code to print magnets
- o_print_strobe  out  1  one-cycle pulse: print cycle start
- o_shift_up / o_shift_down  out  1 each  shift magnet, held for a shift cycle
- o_space  out  1  held for a space cycle
- o_cr  out  1  held for a carriage-return cycle
- o_reject  out  1  one-cycle pulse: unprintable byte dropped
- o_case_upper  out  1  tracked shift state
- o_busy  out  1  (state≠IDLE) | ~o_empty

## Operation
- FIFO: registered, circular, with read/write pointers.
  - A write is accepted when i_wr=1 and o_full=0, where o_full is sampled at the start of the cycle. This holds even if a pop occurs in the same cycle.
  - A write with o_full=1 is dropped and pulses o_overflow.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, FETCH, DECIDE, SHIFT, PRINT, SPACE, CR.
  - IDLE → FETCH when o_empty=0.
  - FETCH: capture the FIFO head into the hold register and pop.
  - DECIDE: o_xlat_data = hold register. Checks are evaluated in this priority order:
    1. hold = SPACE_CODE → SPACE.
    2. hold = NL_CODE → CR.
    3. lc=0 and uc=0 → pulse o_reject, go to IDLE.
    4. Required case is upper when uc=1 and lc=0, lower when lc=1 and uc=0. If lc=1 and uc=1, no shift is needed.
    5. Required case differs from o_case_upper → SHIFT; otherwise → PRINT.
  - SHIFT: hold o_shift_up (to upper) or o_shift_down (to lower) for SHIFT_CYC cycles. Toggle o_case_upper on the last cycle, then go to PRINT.
  - PRINT: latch i_xlat_tt into o_tt on entry and hold it for PRINT_CYC cycles. o_print_strobe is high in the first cycle only. Then go to IDLE.
  - SPACE: o_space high for PRINT_CYC cycles, then IDLE. Case state is unchanged.
  - CR: o_cr high for CR_CYC cycles, then IDLE. Case state is unchanged.
- o_xlat_data holds the hold register in every state.
- Duration counter width: $clog2 of the largest cycle parameter, plus 1.

## Timing
- Reset values:
  - All outputs are 0, except o_empty=1 and o_xlat_data=0.
  - FIFO is emptied, state is IDLE, o_case_upper=0.
  - Reset mid-operation aborts the operation immediately; no completion pulse.
- o_tt=0 outside PRINT.
- o_shift_*, o_space, o_cr and o_tt are registered and glitch-free.
- Latency:
  - Write in cycle 0 to an empty FIFO in IDLE: o_count=1 in cycle 1, FETCH in cycle 2, DECIDE in cycle 3.
  - Operation starts in cycle 4: strobe, space, CR, or shift.
  - With a shift, the strobe falls in cycle 4+SHIFT_CYC.
- Back-to-back: after an operation ends there is one IDLE cycle before the next FETCH.
- o_count reflects a write or pop one cycle after the edge. Write and pop in the same cycle leave o_count unchanged.

## Test plan
- Reset with i_wr held high → all outputs 0, o_empty=1, o_case_upper=0. No write is accepted until reset is released.
- Write 8'h81, translator model returns lc=1, uc=0 → o_print_strobe pulses in cycle 4 and o_tt equals the model's code for 16 cycles. No shift; o_busy falls in cycle 20.
- Write 8'hC1 (uc only) then 8'h81:
  - o_shift_up high in cycles 4–27, strobe in cycle 28, o_case_upper=1.
  - The second byte produces o_shift_down for 24 cycles before its strobe.
- Write 10 bytes back-to-back while idle:
  - o_full asserts.
  - o_overflow pulses for each dropped write: 1 drop, because 1 entry is popped during the burst.
  - The 9 accepted bytes print in write order.
- Write 8'h40, 8'h15, 8'hFF (model lc=uc=0):
  - o_space high for 16 cycles.
  - o_cr high for 64 cycles.
  - o_reject pulses once in the DECIDE cycle, with no strobe.
- Assert i_reset in the 10th SHIFT cycle with 3 bytes queued → all outputs drop asynchronously, o_count=0, o_case_upper=0. Nothing prints after release.
